// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-fills, D-fills and D write-through stores onto one multi-cycle memory port.
// Optional critical-word-first fill order: define CRITICAL_WORD_FIRST_EN.
module cache_fill_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  input  logic                           d_wr,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [15:0]                    d_wr_data,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_rdata,
  input  logic                           mem_valid,
  output logic [15:0]                    fill_word,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
  output logic                           i_fill_we,
  output logic                           d_fill_we,
  output logic                           i_fill_done,
  output logic                           d_fill_done,
  output logic                           d_wr_ack,
  output logic                           fill_crit,
  output logic                           busy
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);

  if (MEM_LATENCY < 1 || BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_param
    $error("cache_fill_arbiter: MEM_LATENCY >= 1 and power-of-2 BLOCK_WORDS >= 2 required");
  end

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_DONE} state_t;

  state_t            state;
  logic              owner_d;     // 1 = current fill belongs to the D-cache
  logic              issuing;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  start_idx;
  logic [IDX_W-1:0]  issue_cnt;
  logic [IDX_W-1:0]  recv_cnt;

  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_base;
  logic [IDX_W-1:0]  sel_start;

  // D-side wins the fill arbitration; stores are handled ahead of both.
  always_comb begin
    sel_addr  = d_miss ? d_miss_addr : i_miss_addr;
    sel_base  = sel_addr & ~OFFS_MASK;
    sel_start = CWF ? sel_addr[IDX_W:1] : '0;
  end

  // Index math wraps inside the block, so the tag bits of base are never disturbed.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [IDX_W-1:0]  idx);
    return b | ADDR_W'({idx, 1'b0});
  endfunction

  // NOTE: every register here is assigned with <= so all of them sample pre-edge values;
  // reset is synchronous, so it is just the first branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner_d     <= 1'b0;
      issuing     <= 1'b0;
      base        <= '0;
      start_idx   <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      fill_word   <= '0;
      fill_idx    <= '0;
      i_fill_we   <= 1'b0;
      d_fill_we   <= 1'b0;
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      d_wr_ack    <= 1'b0;
      fill_crit   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      i_fill_we   <= 1'b0;
      d_fill_we   <= 1'b0;
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      d_wr_ack    <= 1'b0;
      fill_crit   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (d_wr) begin
            state     <= S_WRITE;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= d_wr_addr;
            mem_wdata <= d_wr_data;
          end else if (d_miss || i_miss) begin
            // The first read goes out on the transition so reads occupy FILL's first cycles.
            state     <= S_FILL;
            busy      <= 1'b1;
            owner_d   <= d_miss;
            base      <= sel_base;
            start_idx <= sel_start;
            issue_cnt <= IDX_W'(1);
            recv_cnt  <= '0;
            issuing   <= 1'b1;
            mem_en    <= 1'b1;
            mem_addr  <= word_addr(sel_base, sel_start);
          end
        end
        S_WRITE: begin
          state    <= S_DONE;
          d_wr_ack <= 1'b1;
        end
        S_FILL: begin
          if (issuing) begin
            mem_en    <= 1'b1;
            mem_addr  <= word_addr(base, start_idx + issue_cnt);
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == LAST_IDX) issuing <= 1'b0;
          end
          if (mem_valid) begin
            fill_word <= mem_rdata;
            fill_idx  <= start_idx + recv_cnt;
            d_fill_we <= owner_d;
            i_fill_we <= !owner_d;
            fill_crit <= CWF && (recv_cnt == '0);
            recv_cnt  <= recv_cnt + 1'b1;
            if (recv_cnt == LAST_IDX) begin
              state       <= S_DONE;
              d_fill_done <= owner_d;
              i_fill_done <= !owner_d;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: fill/store vectors scored cycle by cycle
// against an operation schedule, with a fixed-latency memory model.
module tb_cache_fill_arbiter;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss = 1'b0, d_miss = 1'b0, d_wr = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_word;
  logic [2:0]  fill_idx;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, fill_crit, busy;

  always #5 clk = ~clk;

  cache_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .fill_word(fill_word), .fill_idx(fill_idx),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_ack(d_wr_ack), .fill_crit(fill_crit), .busy(busy)
  );

  function automatic logic [15:0] rdata_fn(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Memory: a read strobed in cycle n returns in cycle n+4; inj_valid forces a stray beat.
  logic [3:0]       rv = '0;
  logic [3:0][15:0] ra = '0;
  logic             inj_valid = 1'b0;
  always @(posedge clk) begin
    rv <= {rv[2:0], mem_en & ~mem_wr};
    ra <= {ra[2:0], mem_addr};
  end
  assign mem_valid = rv[3] | inj_valid;
  assign mem_rdata = inj_valid ? 16'hDEAD : rdata_fn(ra[3]);

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, c, act, exp);
    end
  endtask

  // kind: 0 = I-fill, 1 = D-fill, 2 = store. t0 = cycle the arbiter samples it in IDLE.
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] base;
    logic [2:0]  first;
    int          raise;
    int          t0;
    int          abort;
  } op_t;

  op_t ops[$];
  int  inj_at[$];

  function automatic op_t mk(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] base, input logic [2:0] first_cwf,
                             input int raise, input int t0);
    op_t o;
    o.kind  = kind;
    o.addr  = addr;
    o.wdata = wdata;
    o.base  = base;
    o.first = CWF ? first_cwf : 3'd0;
    o.raise = raise;
    o.t0    = t0;
    o.abort = 1 << 30;
    return o;
  endfunction

  task automatic compare(input int c);
    logic        e_en, e_wr, e_iwe, e_dwe, e_idone, e_ddone, e_ack, e_crit, e_busy;
    logic [15:0] e_addr, e_wdata, e_word;
    logic [2:0]  e_idx, ix;
    int          k;
    e_en = 0; e_wr = 0; e_iwe = 0; e_dwe = 0; e_idone = 0; e_ddone = 0;
    e_ack = 0; e_crit = 0; e_busy = 0;
    e_addr = '0; e_wdata = '0; e_word = '0; e_idx = '0;
    foreach (ops[i]) begin
      k = c - ops[i].t0;
      if (c > ops[i].abort) continue;
      if (ops[i].kind == 2) begin
        if (k == 1) begin e_en = 1; e_wr = 1; e_addr = ops[i].addr; e_wdata = ops[i].wdata; end
        if (k == 2) e_ack = 1;
        if (k >= 1 && k <= 2) e_busy = 1;
      end else begin
        if (k >= 1 && k <= 8) begin
          ix = ops[i].first + 3'(k - 1);
          e_en = 1;
          e_addr = ops[i].base | {12'h000, ix, 1'b0};
        end
        if (k >= 6 && k <= 13) begin
          ix = ops[i].first + 3'(k - 6);
          e_idx  = ix;
          e_word = rdata_fn(ops[i].base | {12'h000, ix, 1'b0});
          if (ops[i].kind == 1) e_dwe = 1; else e_iwe = 1;
          e_crit = CWF && (k == 6);
        end
        if (k == 13) begin
          if (ops[i].kind == 1) e_ddone = 1; else e_idone = 1;
        end
        if (k >= 1 && k <= 13) e_busy = 1;
      end
    end
    check("mem_en", c, 32'(mem_en), 32'(e_en));
    if (e_en) begin
      check("mem_wr", c, 32'(mem_wr), 32'(e_wr));
      check("mem_addr", c, 32'(mem_addr), 32'(e_addr));
      if (e_wr) check("mem_wdata", c, 32'(mem_wdata), 32'(e_wdata));
    end
    check("i_fill_we", c, 32'(i_fill_we), 32'(e_iwe));
    check("d_fill_we", c, 32'(d_fill_we), 32'(e_dwe));
    if (e_iwe || e_dwe) begin
      check("fill_idx", c, 32'(fill_idx), 32'(e_idx));
      check("fill_word", c, 32'(fill_word), 32'(e_word));
    end
    check("i_fill_done", c, 32'(i_fill_done), 32'(e_idone));
    check("d_fill_done", c, 32'(d_fill_done), 32'(e_ddone));
    check("d_wr_ack", c, 32'(d_wr_ack), 32'(e_ack));
    check("fill_crit", c, 32'(fill_crit), 32'(e_crit));
    check("busy", c, 32'(busy), 32'(e_busy));
  endtask

  // Runs ncyc cycles: outputs checked mid-cycle, then requests dropped/raised for the next edge.
  task automatic run_window(input int ncyc, input int rst_at);
    int d;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      compare(c);
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("rst_fill_word", c, 32'(fill_word), 32'h0);
        check("rst_fill_idx", c, 32'(fill_idx), 32'h0);
        check("rst_mem_addr", c, 32'(mem_addr), 32'h0);
      end
      inj_valid = 1'b0;
      foreach (inj_at[j]) if (inj_at[j] == c) inj_valid = 1'b1;
      foreach (ops[i]) begin
        d = (ops[i].kind == 2) ? ops[i].t0 + 2 : ops[i].t0 + 13;
        if (c == d) begin
          case (ops[i].kind)
            0:       i_miss = 1'b0;
            1:       d_miss = 1'b0;
            default: d_wr   = 1'b0;
          endcase
        end
      end
      foreach (ops[i]) begin
        if (c == ops[i].raise) begin
          case (ops[i].kind)
            0:       begin i_miss = 1'b1; i_miss_addr = ops[i].addr; end
            1:       begin d_miss = 1'b1; d_miss_addr = ops[i].addr; end
            default: begin d_wr = 1'b1; d_wr_addr = ops[i].addr; d_wr_data = ops[i].wdata; end
          endcase
        end
      end
      if (rst_at >= 0 && c == rst_at) begin
        rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
      end
      if (rst_at >= 0 && c == rst_at + 1) rst = 1'b0;
    end
  endtask

  typedef struct {
    logic        side_d;
    logic [15:0] addr;
    logic [15:0] base;
    logic [2:0]  first_cwf;
  } fill_vec_t;

  fill_vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b0, 16'h0036, 16'h0030, 3'd3};
    vecs[1] = '{1'b1, 16'h2004, 16'h2000, 3'd2};
    vecs[2] = '{1'b0, 16'hFFFE, 16'hFFF0, 3'd7};
    vecs[3] = '{1'b0, 16'h000A, 16'h0000, 3'd5};
    vecs[4] = '{1'b1, 16'h7FF1, 16'h7FF0, 3'd0};

    repeat (5) @(negedge clk);
    check("reset_busy", -1, 32'(busy), 32'h0);
    check("reset_mem_en", -1, 32'(mem_en), 32'h0);
    check("reset_mem_wr", -1, 32'(mem_wr), 32'h0);
    check("reset_mem_addr", -1, 32'(mem_addr), 32'h0);
    check("reset_mem_wdata", -1, 32'(mem_wdata), 32'h0);
    check("reset_fill_word", -1, 32'(fill_word), 32'h0);
    check("reset_fill_idx", -1, 32'(fill_idx), 32'h0);
    check("reset_strobes", -1,
          32'({i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, fill_crit}), 32'h0);
    rst = 1'b0;

    // Isolated fills; stray mem_valid beats in DONE (13) and IDLE (15) must be ignored.
    for (int v = 0; v < 5; v++) begin
      ops.delete();
      inj_at.delete();
      ops.push_back(mk(vecs[v].side_d ? 1 : 0, vecs[v].addr, 16'h0000, vecs[v].base,
                       vecs[v].first_cwf, 0, 0));
      inj_at.push_back(13);
      inj_at.push_back(15);
      run_window(18, -1);
    end
    inj_at.delete();

    // Store and I-miss raised together: store drains first, fill sampled after DONE.
    ops.delete();
    ops.push_back(mk(2, 16'h1000, 16'hBEEF, 16'h0000, 3'd0, 0, 0));
    ops.push_back(mk(0, 16'h0036, 16'h0000, 16'h0030, 3'd3, 0, 3));
    run_window(21, -1);

    // D-miss arrives during an I-fill and waits for the I-side DONE.
    ops.delete();
    ops.push_back(mk(0, 16'h0040, 16'h0000, 16'h0040, 3'd0, 0, 0));
    ops.push_back(mk(1, 16'h2004, 16'h0000, 16'h2000, 3'd2, 3, 14));
    run_window(30, -1);

    // Simultaneous misses: D-side served first.
    ops.delete();
    ops.push_back(mk(1, 16'h3006, 16'h0000, 16'h3000, 3'd3, 0, 0));
    ops.push_back(mk(0, 16'h4008, 16'h0000, 16'h4000, 3'd4, 0, 14));
    run_window(30, -1);

    // Reset while the 4th word returns: fill aborted, late beats dropped.
    ops.delete();
    ops.push_back(mk(0, 16'h0100, 16'h0000, 16'h0100, 3'd0, 0, 0));
    ops[0].abort = 8;
    run_window(18, 8);

    // Back-to-back stores: acks at cycles 2, 5, 8.
    ops.delete();
    ops.push_back(mk(2, 16'h0100, 16'h1111, 16'h0000, 3'd0, 0, 0));
    ops.push_back(mk(2, 16'h0102, 16'h2222, 16'h0000, 3'd0, 2, 3));
    ops.push_back(mk(2, 16'h0104, 16'h3333, 16'h0000, 3'd0, 5, 6));
    run_window(11, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
